fpu_issue_arbiter: RTL and testbench

- Shares one pipelined FPU between REQUESTERS independent requesters.
- Selects one request per cycle using round-robin and drives the FPU stage-1 operation and operand inputs.
- Blocks issue while an iterative divide/sqrt occupies the front end.
- Tracks in-flight operations in an in-order ID FIFO so each FPU result is routed back to the requester that issued it.

---
 rtl/fpu_issue_arbiter.sv | 140 ++++++++++++++
 tb/tb_fpu_issue_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter that shares one pipelined FPU between several requesters.
// An in-order ID FIFO routes each returning result back to the requester that issued it.
module fpu_issue_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_CYCLES = 13
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [REQUESTERS-1:0]           req_valid,
  output logic [REQUESTERS-1:0]           req_ready,
  input  logic [3*REQUESTERS-1:0]         req_op,
  input  logic [32*REQUESTERS-1:0]        req_operand_a,
  input  logic [32*REQUESTERS-1:0]        req_operand_b,
  output logic                            fpu_issue_valid,
  output logic [2:0]                      fpu_issue_op,
  output logic [31:0]                     fpu_operand_a,
  output logic [31:0]                     fpu_operand_b,
  input  logic                            fpu_result_valid,
  input  logic [31:0]                     fpu_result,
  input  logic [4:0]                      fpu_flags,
  output logic [REQUESTERS-1:0]           resp_valid,
  output logic [31:0]                     resp_result,
  output logic [4:0]                      resp_flags,
  output logic [$clog2(FIFO_DEPTH):0]     in_flight,
  output logic                            protocol_error
);

  localparam int IDW = $clog2(REQUESTERS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV_CYCLES + 1);
  localparam logic [PW:0]   FULL      = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);
  localparam logic [2:0]    OP_DIV    = 3'd3;
  localparam logic [2:0]    OP_SQRT   = 3'd4;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic           grant;
  logic           issue_ok;
  logic [CW-1:0]  div_count;
  logic [PW:0]    count;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [IDW-1:0] id_mem [FIFO_DEPTH];
  logic [IDW-1:0] head;
  logic           push;
  logic           pop;
  logic           stray_result;

  // Issue is also held off while reset is asserted so every output reads 0 during reset.
  assign issue_ok = !reset && (div_count == '0) && (count < FULL);

  // NOTE: every signal gets a default before the search loop; a path that skips
  // an assignment in always_comb would otherwise infer a latch.
  always_comb begin
    int idx;
    grant  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < REQUESTERS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= REQUESTERS) idx = idx - REQUESTERS;
      if (issue_ok && !grant && req_valid[idx]) begin
        grant  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign req_ready       = grant ? (REQUESTERS'(1) << winner) : '0;
  assign fpu_issue_valid = grant;
  assign fpu_issue_op    = grant ? req_op[winner*3 +: 3]          : '0;
  assign fpu_operand_a   = grant ? req_operand_a[winner*32 +: 32] : '0;
  assign fpu_operand_b   = grant ? req_operand_b[winner*32 +: 32] : '0;

  assign push         = grant;
  assign pop          = fpu_result_valid && (count != '0);
  assign stray_result = fpu_result_valid && (count == '0);
  assign head         = id_mem[rd_ptr];
  assign in_flight    = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (winner == IDW'(REQUESTERS - 1)) ? '0 : winner + IDW'(1);
    end
  end

  // Div/sqrt occupies the FPU front end; the counter only loads when idle, so no conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_count <= '0;
    end else if (grant && (fpu_issue_op == OP_DIV || fpu_issue_op == OP_SQRT)) begin
      div_count <= DIV_LOAD;
    end else if (div_count != '0) begin
      div_count <= div_count - CW'(1);
    end
  end

  // NOTE: the ID storage is deliberately left without reset; occupancy and pointers
  // are reset, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= winner;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid     <= '0;
      resp_result    <= '0;
      resp_flags     <= '0;
      protocol_error <= 1'b0;
    end else begin
      resp_valid <= pop ? (REQUESTERS'(1) << head) : '0;
      if (pop) begin
        resp_result <= fpu_result;
        resp_flags  <= fpu_flags;
      end
      if (stray_result) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed bench for fpu_issue_arbiter: the bench plays the FPU and scores every
// response against expectations queued when the matching result was returned.
module tb_fpu_issue_arbiter;

  localparam int R  = 2;
  localparam int D  = 8;
  localparam int DC = 13;

  logic              clk = 1'b0;
  logic              reset;
  logic [R-1:0]      req_valid;
  logic [R-1:0]      req_ready;
  logic [3*R-1:0]    req_op;
  logic [32*R-1:0]   req_operand_a;
  logic [32*R-1:0]   req_operand_b;
  logic              fpu_issue_valid;
  logic [2:0]        fpu_issue_op;
  logic [31:0]       fpu_operand_a;
  logic [31:0]       fpu_operand_b;
  logic              fpu_result_valid;
  logic [31:0]       fpu_result;
  logic [4:0]        fpu_flags;
  logic [R-1:0]      resp_valid;
  logic [31:0]       resp_result;
  logic [4:0]        resp_flags;
  logic [$clog2(D):0] in_flight;
  logic              protocol_error;

  fpu_issue_arbiter #(.REQUESTERS(R), .FIFO_DEPTH(D), .DIV_CYCLES(DC)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_operand_a    (req_operand_a),
    .req_operand_b    (req_operand_b),
    .fpu_issue_valid  (fpu_issue_valid),
    .fpu_issue_op     (fpu_issue_op),
    .fpu_operand_a    (fpu_operand_a),
    .fpu_operand_b    (fpu_operand_b),
    .fpu_result_valid (fpu_result_valid),
    .fpu_result       (fpu_result),
    .fpu_flags        (fpu_flags),
    .resp_valid       (resp_valid),
    .resp_result      (resp_result),
    .resp_flags       (resp_flags),
    .in_flight        (in_flight),
    .protocol_error   (protocol_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [R-1:0] who;
    logic [31:0]  res;
    logic [4:0]   flg;
  } resp_t;

  int    issue_q[$];
  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[r]            = v;
    req_op[r*3 +: 3]        = op;
    req_operand_a[r*32 +: 32] = a;
    req_operand_b[r*32 +: 32] = b;
  endtask

  task automatic expect_grant(input string tag, input int g, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b);
    check({tag, "_ready"}, req_ready, 32'(1) << g);
    check({tag, "_valid"}, fpu_issue_valid, 1);
    check({tag, "_op"},    fpu_issue_op, op);
    check({tag, "_a"},     fpu_operand_a, a);
    check({tag, "_b"},     fpu_operand_b, b);
    issue_q.push_back(g);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_valid"}, fpu_issue_valid, 0);
    check({tag, "_op"},    fpu_issue_op, 0);
  endtask

  // Bench acting as the FPU: returns the next in-order result and queues the expected response.
  task automatic fpu_return(input logic [31:0] res, input logic [4:0] f);
    resp_t e;
    int    id;
    fpu_result_valid = 1'b1;
    fpu_result       = res;
    fpu_flags        = f;
    n_checks++;
    if (issue_q.size() == 0) begin
      n_fail++;
      $error("FAIL fpu_return: observed empty issue queue expected an outstanding op");
    end else begin
      id    = issue_q.pop_front();
      e.who = R'(1) << id;
      e.res = res;
      e.flg = f;
      exp_q.push_back(e);
    end
  endtask

  task automatic fpu_idle();
    fpu_result_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && resp_valid !== '0) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", resp_valid, 0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_valid",  resp_valid,  e.who);
        check("resp_result", resp_result, e.res);
        check("resp_flags",  resp_flags,  e.flg);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req_valid = '0; req_op = '0; req_operand_a = '0; req_operand_b = '0;
    fpu_result_valid = 1'b0; fpu_result = '0; fpu_flags = '0;
    #12;
    check("rst_ready",     req_ready, 0);
    check("rst_issue",     fpu_issue_valid, 0);
    check("rst_in_flight", in_flight, 0);
    check("rst_resp",      resp_valid, 0);
    check("rst_result",    resp_result, 0);
    check("rst_perr",      protocol_error, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Single add from R0.
    set_req(0, 1, 3'd0, 32'h3F800000, 32'h40000000); #1;
    expect_grant("single", 0, 3'd0, 32'h3F800000, 32'h40000000);
    step();
    set_req(0, 0, 3'd0, 0, 0);
    check("single_in_flight", in_flight, 1);
    fpu_return(32'h40400000, 5'h00);
    step(); fpu_idle();
    check("single_resp_valid",  resp_valid, 2'b01);
    check("single_resp_result", resp_result, 32'h40400000);
    check("single_drained",     in_flight, 0);
    step();
    check("single_resp_pulse",  resp_valid, 0);

    // Contention: pointer sits at 1 after the R0 grant, so R1 wins first.
    set_req(0, 1, 3'd2, 32'h3F800000, 32'h40000000);
    set_req(1, 1, 3'd2, 32'h40400000, 32'h40000000); #1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) expect_grant("rr", 1, 3'd2, 32'h40400000, 32'h40000000);
      else            expect_grant("rr", 0, 3'd2, 32'h3F800000, 32'h40000000);
      step();
    end
    set_req(0, 0, 3'd0, 0, 0);
    set_req(1, 0, 3'd0, 0, 0);
    check("rr_in_flight", in_flight, 4);
    for (int k = 0; k < 4; k++) begin
      fpu_return((k % 2 == 0) ? 32'h40C00000 : 32'h40000000, (k == 1) ? 5'h01 : 5'h00);
      step();
    end
    fpu_idle();
    step();
    check("rr_drained", in_flight, 0);

    // Divide stall: R1 div, then R0 add waits out the front-end occupancy.
    set_req(1, 1, 3'd3, 32'h41200000, 32'h40000000); #1;
    expect_grant("div", 1, 3'd3, 32'h41200000, 32'h40000000);
    step();
    set_req(1, 0, 3'd0, 0, 0);
    set_req(0, 1, 3'd0, 32'h3F800000, 32'h3F800000); #1;
    expect_idle("div_stall");
    for (int k = 2; k <= 12; k++) begin
      step();
      expect_idle("div_stall");
    end
    step();
    expect_grant("after_div", 0, 3'd0, 32'h3F800000, 32'h3F800000);
    step();
    set_req(0, 0, 3'd0, 0, 0);
    fpu_return(32'h40A00000, 5'h00); step();
    fpu_return(32'h40000000, 5'h00); step();
    fpu_idle(); step();
    check("div_drained", in_flight, 0);

    // FIFO full: eight adds with no results returning.
    set_req(0, 1, 3'd0, 32'h40000000, 32'h3F800000); #1;
    for (int k = 0; k < 8; k++) begin
      expect_grant("fill", 0, 3'd0, 32'h40000000, 32'h3F800000);
      step();
    end
    check("full_in_flight", in_flight, 8);
    expect_idle("full");
    step();
    expect_idle("full_hold");
    fpu_return(32'h41000000, 5'h00); #1;
    expect_idle("full_pop_same_cycle");
    step(); fpu_idle();
    check("full_after_pop_count", in_flight, 7);
    expect_grant("full_after_pop", 0, 3'd0, 32'h40000000, 32'h3F800000);
    step();
    set_req(0, 0, 3'd0, 0, 0);
    check("full_refilled", in_flight, 8);
    for (int k = 0; k < 8; k++) begin
      fpu_return(32'h41100000 + 32'(k), 5'(k));
      step();
    end
    fpu_idle(); step();
    check("full_drained", in_flight, 0);

    // Stray result on an empty FIFO that is being pushed in the same cycle.
    check("perr_before", protocol_error, 0);
    set_req(0, 1, 3'd1, 32'h40400000, 32'h3F800000);
    fpu_result_valid = 1'b1; fpu_result = 32'hDEADBEEF; fpu_flags = 5'h1F; #1;
    expect_grant("perr_push", 0, 3'd1, 32'h40400000, 32'h3F800000);
    step(); fpu_idle();
    set_req(0, 0, 3'd0, 0, 0);
    check("perr_set",       protocol_error, 1);
    check("perr_no_resp",   resp_valid, 0);
    check("perr_no_pop",    in_flight, 1);
    repeat (3) step();
    check("perr_sticky",    protocol_error, 1);
    fpu_return(32'h40000000, 5'h00); step();
    fpu_idle(); step();
    check("perr_drained",   in_flight, 0);
    check("perr_still_set", protocol_error, 1);

    // Reset mid-flight with three ops outstanding and the div counter at 7.
    set_req(0, 1, 3'd0, 32'h3F800000, 32'h3F800000); #1;
    expect_grant("mid_add0", 0, 3'd0, 32'h3F800000, 32'h3F800000);
    step();
    expect_grant("mid_add1", 0, 3'd0, 32'h3F800000, 32'h3F800000);
    step();
    set_req(0, 0, 3'd0, 0, 0);
    set_req(1, 1, 3'd4, 32'h40800000, 32'h00000000); #1;
    expect_grant("mid_sqrt", 1, 3'd4, 32'h40800000, 32'h00000000);
    step();
    set_req(1, 0, 3'd0, 0, 0);
    repeat (5) step();
    check("mid_in_flight", in_flight, 3);
    set_req(0, 1, 3'd0, 32'h40000000, 32'h40000000); #1;
    expect_idle("mid_blocked");
    #1 reset = 1'b1;
    #1;
    check("arst_in_flight", in_flight, 0);
    check("arst_ready",     req_ready, 0);
    check("arst_issue",     fpu_issue_valid, 0);
    check("arst_op_a",      fpu_operand_a, 0);
    check("arst_resp",      resp_valid, 0);
    check("arst_result",    resp_result, 0);
    check("arst_flags",     resp_flags, 0);
    check("arst_perr",      protocol_error, 0);
    issue_q.delete();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_grant("post_reset", 0, 3'd0, 32'h40000000, 32'h40000000);
    step();
    set_req(0, 0, 3'd0, 0, 0);
    fpu_return(32'h40800000, 5'h00); step();
    fpu_idle(); step();
    check("post_reset_drained", in_flight, 0);

    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 0);
    check("issue_q_empty",    issue_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
